// File: rtl/store_align_if.sv
// store_align_if: request and memory-beat signals of the store alignment unit.
//   req_valid/req_ready/req_addr/req_data/req_size : store request handshake
//   mem_valid/mem_ready/mem_addr/mem_be/mem_wdata  : memory write beat handshake
//   done/err                                       : completion / rejection pulses
// Modport slave is the alignment unit; modport master is the requester/memory side.
interface store_align_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        done;
   logic        err;
   modport slave (
      input  req_valid, req_addr, req_data, req_size, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, err
   );
   modport master (
      output req_valid, req_addr, req_data, req_size, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_be, mem_wdata, done, err
   );
endinterface

// File: rtl/store_align_unit.sv
// store_align_unit: turns byte/half/word stores into lane-positioned word-aligned memory beats.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : store_align_if.slave (request in, memory beat out, done/err pulses)
// Macro STORE_MISALIGN_SPLIT_EN: when defined, stores crossing a word boundary are issued
// as two beats; when undefined they are rejected with err like an illegal size.
module store_align_unit (
   input logic          clk,
   input logic          rst_n,
   store_align_if.slave bus
);
`ifdef STORE_MISALIGN_SPLIT_EN
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
   typedef enum logic [1:0] {IDLE, BEAT0} state_t;
`endif
   state_t      state, state_nx;
   logic        rdy, ready, accept, reject, split_in, last;
   logic [2:0]  in_n;
   logic [31:0] addr_q, data_q, dm, base, wd0, maddr, mwdata;
   logic [1:0]  size_q, o;
   logic [3:0]  mask, be0, mbe;
   logic        valid, done_q, err_q;
`ifdef STORE_MISALIGN_SPLIT_EN
   logic        split_q;
   logic [3:0]  be1;
   logic [31:0] wd1;
`endif
   // rdy holds ready low until the first edge after reset release
   assign ready    = rdy & (state == IDLE);
   assign accept   = bus.req_valid & ready;
   assign in_n     = bus.req_size == 2'b00 ? 3'd1 : bus.req_size == 2'b01 ? 3'd2 : 3'd4;
   assign split_in = ({1'b0, bus.req_addr[1:0]} + in_n) > 3'd4;
`ifdef STORE_MISALIGN_SPLIT_EN
   assign reject   = bus.req_size == 2'b11;
`else
   assign reject   = bus.req_size == 2'b11 || split_in;
`endif
   assign o    = addr_q[1:0];
   assign mask = size_q == 2'b00 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
   // clear bits above the access size so unused lanes stay zero
   assign dm   = size_q == 2'b00 ? {24'b0, data_q[7:0]} :
                 size_q == 2'b01 ? {16'b0, data_q[15:0]} : data_q;
   assign base = {addr_q[31:2], 2'b00};
   assign be0  = mask << o;
   assign wd0  = dm << {o, 3'b000};
`ifdef STORE_MISALIGN_SPLIT_EN
   // second beat carries the bytes that spilled past lane 3
   assign be1  = mask >> (3'd4 - {1'b0, o});
   assign wd1  = dm >> (6'd32 - {1'b0, o, 3'b000});
`endif
   always_comb begin
      state_nx = state;
      valid    = 1'b0;
      maddr    = '0;
      mbe      = '0;
      mwdata   = '0;
      last     = 1'b0;
      case (state)
         IDLE:  if (accept && !reject) state_nx = BEAT0;
         BEAT0: begin
            valid  = 1'b1;
            maddr  = base;
            mbe    = be0;
            mwdata = wd0;
`ifdef STORE_MISALIGN_SPLIT_EN
            last   = !split_q;
            if (bus.mem_ready) state_nx = split_q ? BEAT1 : IDLE;
`else
            last   = 1'b1;
            if (bus.mem_ready) state_nx = IDLE;
`endif
         end
`ifdef STORE_MISALIGN_SPLIT_EN
         BEAT1: begin
            valid  = 1'b1;
            maddr  = base + 32'd4;
            mbe    = be1;
            mwdata = wd1;
            last   = 1'b1;
            if (bus.mem_ready) state_nx = IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rdy    <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         size_q <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
         split_q <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         rdy    <= 1'b1;
         done_q <= last & bus.mem_ready;
         err_q  <= accept & reject;
         if (accept) begin
            addr_q <= bus.req_addr;
            data_q <= bus.req_data;
            size_q <= bus.req_size;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_q <= split_in;
`endif
         end
      end
   end
   assign bus.req_ready = ready;
   assign bus.mem_valid = valid;
   assign bus.mem_addr  = maddr;
   assign bus.mem_be    = mbe;
   assign bus.mem_wdata = mwdata;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_store_align_unit.sv
// tb_store_align_unit: directed bench for store_align_unit (default and STORE_MISALIGN_SPLIT_EN builds).
module tb_store_align_unit;
`ifdef STORE_MISALIGN_SPLIT_EN
   localparam bit SP = 1'b1;
`else
   localparam bit SP = 1'b0;
`endif
   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
      logic        split;
      logic [3:0]  be0;
      logic [31:0] wd0;
      logic [3:0]  be1;
      logic [31:0] wd1;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int checks = 0;
   int errors = 0;
   int cur = -1;
   vec_t v [0:11];
   store_align_if bus();
   store_align_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (vec %0d): got %h, expected %h", nm, cur, act, exp);
      end
   endtask
   task automatic chk_idle_zero();
      chk("rst mem_valid", bus.mem_valid, 0);
      chk("rst mem_be", bus.mem_be, 0);
      chk("rst mem_addr", bus.mem_addr, 0);
      chk("rst mem_wdata", bus.mem_wdata, 0);
      chk("rst done", bus.done, 0);
      chk("rst err", bus.err, 0);
      chk("rst req_ready", bus.req_ready, 0);
   endtask
   task automatic run_vec(input vec_t t, input bit b2b);
      logic rej;
      logic [31:0] a0;
      rej = (t.size == 2'b11) || (t.split && !SP);
      a0  = {t.addr[31:2], 2'b00};
      if (!b2b) @(negedge clk);
      chk("req_ready", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.req_addr  = t.addr;
      bus.req_data  = t.data;
      bus.req_size  = t.size;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (rej) begin
         chk("err pulse", bus.err, 1);
         chk("err no beat", bus.mem_valid, 0);
         chk("err stays idle", bus.req_ready, 1);
         @(negedge clk);
         chk("err one cycle", bus.err, 0);
         chk("err no beat later", bus.mem_valid, 0);
      end else begin
         chk("b0 valid", bus.mem_valid, 1);
         chk("b0 addr", bus.mem_addr, a0);
         chk("b0 be", bus.mem_be, t.be0);
         chk("b0 wdata", bus.mem_wdata, t.wd0);
         chk("b0 done", bus.done, 0);
         chk("b0 err", bus.err, 0);
         chk("b0 ready", bus.req_ready, 0);
         if (t.split) begin
            @(negedge clk);
            chk("b1 valid", bus.mem_valid, 1);
            chk("b1 addr", bus.mem_addr, a0 + 32'd4);
            chk("b1 be", bus.mem_be, t.be1);
            chk("b1 wdata", bus.mem_wdata, t.wd1);
            chk("b1 done", bus.done, 0);
         end
         @(negedge clk);
         chk("done pulse", bus.done, 1);
         chk("done no beat", bus.mem_valid, 0);
         chk("done ready", bus.req_ready, 1);
      end
   endtask
   initial begin
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      bus.req_size  = '0;
      bus.mem_ready = 1'b0;
      v[0]  = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 4'b1111, 32'hDEAD_BEEF, 4'b0000, 32'h0};
      v[1]  = '{32'h0000_0203, 32'h0000_00A5, 2'b00, 1'b0, 4'b1000, 32'hA500_0000, 4'b0000, 32'h0};
      v[2]  = '{32'h0000_0201, 32'hCAFE_0077, 2'b00, 1'b0, 4'b0010, 32'h0000_7700, 4'b0000, 32'h0};
      v[3]  = '{32'h0000_0302, 32'h0000_1234, 2'b01, 1'b0, 4'b1100, 32'h1234_0000, 4'b0000, 32'h0};
      v[4]  = '{32'h0000_0500, 32'hAAAA_5678, 2'b01, 1'b0, 4'b0011, 32'h0000_5678, 4'b0000, 32'h0};
      v[5]  = '{32'h0000_0303, 32'h0000_BEEF, 2'b01, 1'b1, 4'b1000, 32'hEF00_0000, 4'b0001, 32'h0000_00BE};
      v[6]  = '{32'h0000_0401, 32'h1122_3344, 2'b10, 1'b1, 4'b1110, 32'h2233_4400, 4'b0001, 32'h0000_0011};
      v[7]  = '{32'h0000_0602, 32'hAABB_CCDD, 2'b10, 1'b1, 4'b1100, 32'hCCDD_0000, 4'b0011, 32'h0000_AABB};
      v[8]  = '{32'h0000_0703, 32'h0102_0304, 2'b10, 1'b1, 4'b1000, 32'h0400_0000, 4'b0111, 32'h0001_0203};
      v[9]  = '{32'h0000_0800, 32'h1234_5678, 2'b11, 1'b0, 4'b0000, 32'h0,         4'b0000, 32'h0};
      v[10] = '{32'h0000_0900, 32'h1234_5678, 2'b00, 1'b0, 4'b0001, 32'h0000_0078, 4'b0000, 32'h0};
      v[11] = '{32'hFFFF_FFFC, 32'h5555_AAAA, 2'b10, 1'b0, 4'b1111, 32'h5555_AAAA, 4'b0000, 32'h0};
      #1 rst_n = 1'b0;
      #1 chk_idle_zero();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("ready before first edge", bus.req_ready, 0);
      @(negedge clk);
      chk("ready after first edge", bus.req_ready, 1);
      for (int i = 0; i < 12; i++) begin
         cur = i;
         run_vec(v[i], 1'b0);
      end
      cur = 100;
      run_vec(v[0], 1'b0);
      run_vec(v[10], 1'b1);
      cur = 200;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0302;
      bus.req_data  = 32'h0000_1234;
      bus.req_size  = 2'b01;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("stall valid", bus.mem_valid, 1);
         chk("stall addr", bus.mem_addr, 32'h0000_0300);
         chk("stall be", bus.mem_be, 4'b1100);
         chk("stall wdata", bus.mem_wdata, 32'h1234_0000);
         chk("stall done", bus.done, 0);
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      chk("stall release valid", bus.mem_valid, 1);
      chk("stall release wdata", bus.mem_wdata, 32'h1234_0000);
      @(negedge clk);
      chk("stall done pulse", bus.done, 1);
      chk("stall done no beat", bus.mem_valid, 0);
      @(negedge clk);
      chk("stall done one cycle", bus.done, 0);
      cur = 300;
`ifdef STORE_MISALIGN_SPLIT_EN
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'hFFFF_FFFE;
      bus.req_data  = 32'hCAFE_BABE;
      bus.req_size  = 2'b10;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("wrap b0 addr", bus.mem_addr, 32'hFFFF_FFFC);
      chk("wrap b0 be", bus.mem_be, 4'b1100);
      chk("wrap b0 wdata", bus.mem_wdata, 32'hBABE_0000);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("wrap b1 valid", bus.mem_valid, 1);
      chk("wrap b1 addr", bus.mem_addr, 32'h0000_0000);
      chk("wrap b1 be", bus.mem_be, 4'b0011);
      chk("wrap b1 wdata", bus.mem_wdata, 32'h0000_CAFE);
`else
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0100;
      bus.req_data  = 32'hDEAD_BEEF;
      bus.req_size  = 2'b10;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("midop b0 valid", bus.mem_valid, 1);
      chk("midop b0 addr", bus.mem_addr, 32'h0000_0100);
`endif
      #1 rst_n = 1'b0;
      #1 chk_idle_zero();
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_ready = 1'b1;
      chk("midop ready before edge", bus.req_ready, 0);
      chk("midop no beat", bus.mem_valid, 0);
      @(negedge clk);
      chk("midop ready after edge", bus.req_ready, 1);
      chk("midop no beat after", bus.mem_valid, 0);
      chk("midop no done", bus.done, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
